// File: rtl/mcs6530_timer.sv
// MCS6530 interval timer: 8-bit down-counter behind a 1/8/64/1024 prescaler,
// with an interrupt flag and enable driving the active-low IRQ level.
module mcs6530_timer (
   input  logic       phi2,
   input  logic       rst,
   input  logic       sel,
   input  logic       we,
   input  logic [3:0] a,
   input  logic [7:0] di,
   output logic [7:0] dout,
   output logic       irq_flag,
   output logic       irq_en,
   output logic       irq
);

   logic [7:0] count;
   logic [9:0] pre;
   logic [1:0] div;
   logic       fast;
   logic       flag;
   logic       en;

   logic       wr;
   logic       rd_tmr;
   logic       rd_sts;
   logic       dec;
   logic       underflow;
   logic       unused_a2;

   function automatic logic [9:0] reload(input logic [1:0] d);
      case (d)
         2'b00:   reload = 10'd0;
         2'b01:   reload = 10'd7;
         2'b10:   reload = 10'd63;
         default: reload = 10'd1023;
      endcase
   endfunction

   always_comb begin
      wr        = sel & we;
      rd_tmr    = sel & ~we & ~a[0];
      rd_sts    = sel & ~we & a[0];
      dec       = (pre == 10'd0);
      underflow = ~wr & dec & (count == 8'h00);
      unused_a2 = a[2];
   end

   always_ff @(posedge phi2) begin
      if (rst) begin
         count <= 8'hFF;
         pre   <= 10'd0;
         div   <= 2'b00;
         fast  <= 1'b0;
         flag  <= 1'b0;
         en    <= 1'b0;
      end else if (wr) begin
         count <= di;
         div   <= a[1:0];
         en    <= a[3];
         pre   <= reload(a[1:0]);
         fast  <= 1'b0;
         flag  <= 1'b0;
      end else begin
         if (!dec) begin
            pre <= pre - 10'd1;
         end else begin
            count <= count - 8'd1;
            // Underflow drops straight into divide-by-one, so the next
            // decrement lands on the very next edge.
            if (count == 8'h00) begin
               pre  <= 10'd0;
               fast <= 1'b1;
            end else begin
               pre <= fast ? 10'd0 : reload(div);
            end
         end
         if (underflow)
            flag <= 1'b1;
         else if (rd_tmr)
            flag <= 1'b0;
         if (rd_tmr)
            en <= a[3];
      end
   end

   always_comb begin
      dout = 8'h00;
      if (rd_tmr)
         dout = count;
      else if (rd_sts)
         dout = {flag, 7'b0};
   end

   assign irq_flag = flag;
   assign irq_en   = en;
   assign irq      = ~(flag & en);

endmodule

// File: tb/tb_mcs6530_timer.sv
// Scoreboard bench for mcs6530_timer: a closed-form timing model predicts the
// outputs of every cycle; a separate monitor pops and compares them.
module tb_mcs6530_timer;

   logic       phi2 = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       we = 1'b0;
   logic [3:0] a = 4'h0;
   logic [7:0] di = 8'h00;
   logic [7:0] dout;
   logic       irq_flag;
   logic       irq_en;
   logic       irq;

   mcs6530_timer dut (
      .phi2     (phi2),
      .rst      (rst),
      .sel      (sel),
      .we       (we),
      .a        (a),
      .di       (di),
      .dout     (dout),
      .irq_flag (irq_flag),
      .irq_en   (irq_en),
      .irq      (irq)
   );

   always #5 phi2 = ~phi2;

   typedef struct {
      logic [7:0] dout;
      logic       flag;
      logic       en;
      logic       irq;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   done = 0;

   // Model: last load at edge m_k with value m_n and divisor m_d; flag cleared
   // last at edge m_clr. Everything else follows from elapsed edge counts.
   longint m_t = 0;
   longint m_k = 0;
   longint m_clr = 0;
   int     m_n = 255;
   int     m_d = 1;
   bit     m_en = 0;
   bit     m_valid = 0;
   string  cur_tag = "init";

   function automatic int divisor(input logic [1:0] s);
      case (s)
         2'b00:   return 1;
         2'b01:   return 8;
         2'b10:   return 64;
         default: return 1024;
      endcase
   endfunction

   function automatic longint first_uf();
      return m_k + longint'(m_n + 1) * longint'(m_d);
   endfunction

   function automatic int count_at(input longint t);
      longint d = t - m_k;
      longint span = longint'(m_n + 1) * longint'(m_d);
      if (d < span) return m_n - int'(d / m_d);
      return 255 - int'((d - span) % 256);
   endfunction

   function automatic bit is_uf(input longint t);
      longint f = first_uf();
      return (t >= f) && (((t - f) % 256) == 0);
   endfunction

   function automatic bit flag_at(input longint t);
      longint f = first_uf();
      longint last;
      if (t < f) return 0;
      last = f + ((t - f) / 256) * 256;
      return last > m_clr;
   endfunction

   task automatic drive(input bit r, input bit s, input bit w, input logic [3:0] aa,
                        input logic [7:0] dd);
      exp_t e;
      bit   f;
      @(negedge phi2);
      rst = r; sel = s; we = w; a = aa; di = dd;
      if (!r && m_valid) begin
         f = flag_at(m_t);
         e.dout = 8'h00;
         if (s && !w) e.dout = aa[0] ? {f, 7'b0} : 8'(count_at(m_t));
         e.flag = f;
         e.en   = m_en;
         e.irq  = ~(f & m_en);
         e.tag  = cur_tag;
         exp_q.push_back(e);
      end
      @(posedge phi2);
      m_t++;
      if (r) begin
         m_k = m_t; m_n = 255; m_d = 1; m_clr = m_t; m_en = 0; m_valid = 1;
      end else if (s && w) begin
         m_k = m_t; m_n = int'(dd); m_d = divisor(aa[1:0]); m_clr = m_t; m_en = aa[3];
      end else if (s && !w && !aa[0]) begin
         m_en = aa[3];
         if (!is_uf(m_t)) m_clr = m_t;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge phi2);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks += 4;
            if (dout !== e.dout) begin
               n_fail++;
               $display("FAIL %s dout t=%0t got %h exp %h", e.tag, $time, dout, e.dout);
            end
            if (irq_flag !== e.flag) begin
               n_fail++;
               $display("FAIL %s irq_flag t=%0t got %b exp %b", e.tag, $time, irq_flag, e.flag);
            end
            if (irq_en !== e.en) begin
               n_fail++;
               $display("FAIL %s irq_en t=%0t got %b exp %b", e.tag, $time, irq_en, e.en);
            end
            if (irq !== e.irq) begin
               n_fail++;
               $display("FAIL %s irq t=%0t got %b exp %b", e.tag, $time, irq, e.irq);
            end
         end
      end
   end

   initial begin : stim
      int r;
      cur_tag = "reset";
      drive(1, 0, 0, 4'h0, 8'h00);
      drive(1, 0, 0, 4'h0, 8'h00);
      drive(0, 1, 0, 4'b0000, 8'h00);
      for (int i = 0; i < 300; i++) drive(0, 1, 0, 4'b0001, 8'h00);

      cur_tag = "div8_irq";
      drive(0, 1, 1, 4'b1001, 8'h03);
      for (int i = 0; i < 10; i++) drive(0, 1, 0, 4'b1000, 8'h00);
      for (int i = 0; i < 26; i++) drive(0, 1, 0, 4'b1001, 8'h00);

      cur_tag = "read_clear";
      drive(0, 1, 0, 4'b0001, 8'h00);
      drive(0, 1, 0, 4'b1000, 8'h00);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 4'b0000, 8'h00);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 4'b1000, 8'h00);

      cur_tag = "read_vs_uf";
      drive(0, 1, 1, 4'b0000, 8'h00);
      drive(0, 1, 0, 4'b0000, 8'h00);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 4'b0001, 8'h00);

      cur_tag = "div1024_rewrite";
      drive(0, 1, 1, 4'b0011, 8'h01);
      for (int i = 0; i < 999; i++) drive(0, 0, 0, 4'b0000, 8'h00);
      drive(0, 1, 1, 4'b1000, 8'h05);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 4'b1001, 8'h00);
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 4'b0001, 8'h00);

      cur_tag = "reset_mid";
      drive(0, 1, 1, 4'b1000, 8'h00);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 4'b0000, 8'h00);
      drive(1, 1, 1, 4'b1000, 8'h07);
      drive(0, 1, 0, 4'b0000, 8'h00);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 4'b0001, 8'h00);

      cur_tag = "random";
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 999));
         if (r < 4)
            drive(1, 0, 0, 4'h0, 8'h00);
         else if (r < 24)
            drive(0, 1, 1, 4'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                  8'($urandom_range(0, 6)));
         else if (r < 400)
            drive(0, 1, 0, 4'($urandom), 8'($urandom));
         else
            drive(0, 0, 1'($urandom), 4'($urandom), 8'($urandom));
      end

      drive(0, 0, 0, 4'h0, 8'h00);
      repeat (3) @(posedge phi2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
      end
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      if (!done) begin
         $display("FAIL watchdog timeout got running exp finished");
         $fatal(1, "timeout");
      end
   end

endmodule

// File: doc/mcs6530_timer.md
# mcs6530_timer

Interval timer and interrupt stage of the MCS6530 (RRIOT) replacement. It sits inside the `mcs6530` core, after address/chip-select decode. It takes decoded timer accesses, runs an 8-bit down-counter behind a selectable 1/8/64/1024 prescaler, and produces the read data plus the `irq`/`irq_en` pair that the top level drives onto PB7 (the IRQ pin).

## Interface
- No parameters.
- `phi2` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `sel` in 1: timer access this cycle (decoded chip select AND timer address space).
- `we` in 1: 1 = write, 0 = read; meaningful only when `sel`=1.
- `a` in 4: low address bits.
  - `a[3]`: IRQ enable.
  - `a[1:0]`: divide select.
  - `a[0]` on reads: 0 = timer, 1 = status.
- `di` in 8: write data.
- `do` out 8: read data, combinational from current state and `a`.
- `irq_flag` out 1: timer interrupt flag.
- `irq_en` out 1: interrupt enable bit.
- `irq` out 1: active-low IRQ level, equal to ~(`irq_flag` & `irq_en`).

## Operation
- **State**
  - `count[7:0]`
  - `pre[9:0]` (prescale counter)
  - `div[1:0]`
  - `fast` (post-underflow ÷1 mode)
  - `flag`
  - `en`
- **Divisor D** from `div`: 00→1, 01→8, 10→64, 11→1024. When `fast`=1, D=1 regardless of `div`.
- **Write** (`sel`&`we`):
  - `count`←`di`, `div`←`a[1:0]`, `en`←`a[3]`.
  - `pre`←D(new `div`)−1.
  - `fast`←0, `flag`←0.
  - Takes priority over any tick in the same cycle.
- **Tick**, when there is no write:
  - If `pre`≠0: `pre`←`pre`−1.
  - Otherwise, a decrement event: `count`←`count`−1 (8-bit wrap), and `pre`←D−1 using the current `fast`/`div`.
- **Underflow**: a decrement event with `count`=0x00.
  - `count`→0xFF.
  - `flag`←1.
  - `fast`←1, so from then on `count` decrements every cycle and keeps wrapping.
- **Read timer** (`sel`&~`we`&~`a[0]`):
  - `do`=`count`.
  - `en`←`a[3]`.
  - `flag`←0, unless an underflow occurs in the same cycle; underflow wins and `flag`=1.
  - `fast` is unchanged.
- **Read status** (`sel`&~`we`&`a[0]`):
  - `do`={`flag`,7'b0}.
  - No side effects.
- **`do` with no access** (`sel`=0): `do`=8'h00.
- **Outputs**: `irq_en`=`en`, `irq_flag`=`flag`, `irq`=~(`flag`&`en`).

## Timing
- **Reset values**:
  - `count`=0xFF, `div`=00, `pre`=0, `fast`=0.
  - `flag`=0, `en`=0.
  - Outputs: `irq`=1, `irq_en`=0, `irq_flag`=0, `do`=0x00.
- **Reset mid-count** overrides any access or tick in the same cycle.
- **Write cadence**: write of N with divisor D at edge k.
  - `count`=N over edges k..k+D−1.
  - `count`=N−1 at edge k+D.
  - Underflow occurs at edge k+(N+1)·D, where `count`=0xFF and `flag`=1.
  - Afterwards `count` decrements at every edge: 0xFE at k+(N+1)·D+1, and so on.
- **N=0**: underflow at edge k+D.
- **`irq` latency**:
  - Goes low in the same cycle `flag` and `en` are both 1; no extra latency.
  - Goes high the cycle after a flag-clearing timer read, or after a read/write with `a[3]`=0.
- **Back-to-back writes**: each write restarts the prescaler; there is no carry-over of `pre`.

## Test plan
1. **Reset, no access**:
   - `rst` for 2 cycles, then idle.
   - `count` reads 0xFF and `irq`=1.
   - `flag` rises exactly 256 edges after reset release.
   - `irq` stays 1 because `en`=0.
2. **÷8 with IRQ**:
   - Write `di`=0x03, `a`=4'b1001 at edge k.
   - `count`=0x03 until k+7 and 0x02 at k+8.
   - `flag`=1 and `irq`=0 at k+32, with `count`=0xFF.
   - `count`=0xFE at k+33.
3. **Read clears flag**:
   - After scenario 2, read timer with `a`=4'b1000.
   - `flag`=0 next cycle, `irq`=1, `en` stays 1.
   - Counter keeps ÷1 decrementing.
   - Status read (`a`=4'b0001) beforehand returns 0x80 and does not clear `flag`.
4. **Simultaneous read and underflow**:
   - ÷1 write 0x00 at edge k; timer read scheduled at edge k+1.
   - `flag`=1 after k+1 (underflow wins).
5. **÷1024 and rewrite**:
   - Write 0x01, `a[1:0]`=11 at edge k.
   - At k+1000, write 0x05 with `a[1:0]`=00: `count`=0x04 at k+1001, underflow at k+1006.
   - No stale prescale.
6. **Reset mid-operation**:
   - Assert `rst` while `flag`=1, `en`=1, `fast`=1.
   - Next edge: all state at reset values, `irq`=1.
